// File: rtl/riscv_pkg.sv
// Shared types and constants for the register-file responder slice.
// Pure declarations; no logic, no latency.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RSP  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_responder_if.sv
// Operand-load / result-store exchange between execute logic (master) and the register file (slave).
// Request and write-back use valid/ready; done and err_timeout are one-cycle pulses with no ready.
interface regfile_responder_if #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int AW   = riscv_pkg::REG_ADDR_W
) ();

  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rsp_valid;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            wb_valid;
  logic            wb_ready;
  logic            reg_write;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] rd_val;
  logic            done;
  logic            err_timeout;

  modport master (
    output req_valid, rs1, rs2, wb_valid, reg_write, rd, rd_val,
    input  req_ready, rsp_valid, rs1_val, rs2_val, wb_ready, done, err_timeout
  );

  modport slave (
    input  req_valid, rs1, rs2, wb_valid, reg_write, rd, rd_val,
    output req_ready, rsp_valid, rs1_val, rs2_val, wb_ready, done, err_timeout
  );

endinterface

// File: rtl/regfile_array.sv
// Register file: two registered read ports, one write port, one combinational debug read; x0 reads 0.
// Reads land one edge after rd_en; writes land at the edge; no backpressure.
module regfile_array #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic [$clog2(NREG)-1:0] raddr1,
  input  logic [$clog2(NREG)-1:0] raddr2,
  output logic [XLEN-1:0]         rdata1,
  output logic [XLEN-1:0]         rdata2,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [XLEN-1:0]         dbg_data
);
  import riscv_pkg::X0;

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      if (we && (waddr != AW'(X0))) begin
        mem[waddr] <= wdata;
      end
      // Read and write never share an edge in the responder, so no bypass path.
      if (rd_en) begin
        rdata1 <= (raddr1 == AW'(X0)) ? '0 : mem[raddr1];
        rdata2 <= (raddr2 == AW'(X0)) ? '0 : mem[raddr2];
      end
    end
  end

  assign dbg_data = (dbg_addr == AW'(X0)) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/regfile_responder.sv
// Register-file responder: operands valid 1 cycle after request; one write-back per request; done pulse.
// Holds operands in RSP until write-back; watchdog aborts after TIMEOUT stalled cycles (0 disables).
module regfile_responder #(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int NREG    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_responder_if.slave      bus,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [XLEN-1:0]         dbg_data
);
  import riscv_pkg::*;

  localparam int AW = $clog2(NREG);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e        state;
  logic [CW-1:0] wd_cnt;
  logic          err_q;
  logic          accept;
  logic          wr_en;
  logic          wd_expire;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign wr_en     = (state == RSP) && bus.wb_valid && bus.reg_write && (bus.rd != AW'(X0));
  assign wd_expire = (TIMEOUT != 0) && (state == RSP) && !bus.wb_valid
                     && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state <= RSP;
          end
        end
        RSP: begin
          // A write-back arriving on the expiry cycle still wins over the abort.
          if (bus.wb_valid) begin
            state  <= DONE;
            wd_cnt <= '0;
          end else if (wd_expire) begin
            state  <= IDLE;
            wd_cnt <= '0;
            err_q  <= 1'b1;
          end else if (TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          wd_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.rsp_valid   = (state == RSP);
  assign bus.wb_ready    = (state == RSP);
  assign bus.done        = (state == DONE);
  assign bus.err_timeout = err_q;

  regfile_array #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (accept),
    .raddr1   (bus.rs1),
    .raddr2   (bus.rs2),
    .rdata1   (bus.rs1_val),
    .rdata2   (bus.rs2_val),
    .we       (wr_en),
    .waddr    (bus.rd),
    .wdata    (bus.rd_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule
